// File: rtl/unified_mem_arbiter_if.sv
// rtl/unified_mem_arbiter_if.sv - requester, RAM and stall signal bundle for the unified memory arbiter
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // IF stage side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  // MEM stage side
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  // RAM side
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ack;
  logic [DATA_W-1:0] ram_rdata;
  // pipeline control
  logic              pipe_stall;
  logic              fetch_stall;
  logic              bus_err;

  // arbiter view
  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_ack, ram_rdata,
    output if_ready, if_rdata, mem_ready, mem_rdata,
    output ram_req, ram_we, ram_addr, ram_wdata,
    output pipe_stall, fetch_stall, bus_err
  );

  // pipeline stages plus RAM view
  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_ack, ram_rdata,
    input  if_ready, if_rdata, mem_ready, mem_rdata,
    input  ram_req, ram_we, ram_addr, ram_wdata,
    input  pipe_stall, fetch_stall, bus_err
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one single-ported RAM between instruction fetch and load/store
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 rst,
  unified_mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, RESP} state_t;

  state_t            state_q;
  logic              ram_req_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              if_ready_q;
  logic              mem_ready_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              bus_err_q;
  logic [CNT_W-1:0]  wait_q;
  logic [CNT_W-1:0]  wait_d;

  logic mem_access;
  logic timeout_hit;
  logic pipe_stall;

  // A store wins over a load when both strobes are high, so any strobe means a data access.
  assign mem_access  = bus.mem_rd | bus.mem_wr;
  // wait_d counts the busy cycle now ending; reaching TIMEOUT means ram_req has been up TIMEOUT cycles.
  assign wait_d      = wait_q + CNT_W'(1);
  assign timeout_hit = (wait_d == CNT_W'(TIMEOUT));

  // Single access at a time: launch from IDLE, wait for ack or timeout, one RESP cycle, back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      bus_err_q   <= 1'b0;
      wait_q      <= '0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          wait_q <= '0;
          // Data first: the load/store belongs to an older instruction than the fetch.
          if (mem_access) begin
            state_q     <= DBUSY;
            ram_req_q   <= 1'b1;
            ram_we_q    <= bus.mem_wr;
            ram_addr_q  <= bus.mem_addr;
            ram_wdata_q <= bus.mem_wdata;
          end else if (bus.if_req) begin
            state_q    <= IBUSY;
            ram_req_q  <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_addr_q <= bus.if_addr;
          end
        end
        IBUSY, DBUSY: begin
          wait_q <= wait_d;
          // An ack in the final allowed cycle still counts as a normal completion.
          if (bus.ram_ack || timeout_hit) begin
            ram_req_q <= 1'b0;
            state_q   <= RESP;
            if (state_q == IBUSY) begin
              if_ready_q <= 1'b1;
              if_rdata_q <= bus.ram_ack ? bus.ram_rdata : '0;
            end else begin
              mem_ready_q <= 1'b1;
              if (!ram_we_q) begin
                mem_rdata_q <= bus.ram_ack ? bus.ram_rdata : '0;
              end
            end
            if (!bus.ram_ack) begin
              bus_err_q <= 1'b1;
            end
          end
        end
        RESP: begin
          // Requesters still present the completed access here, so nothing is launched.
          wait_q  <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pipe_stall      = mem_access & ~mem_ready_q;
  assign bus.pipe_stall  = pipe_stall;
  assign bus.fetch_stall = pipe_stall | (bus.if_req & ~if_ready_q);

  assign bus.ram_req   = ram_req_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Sequential arbiter that shares one single-ported unified instruction/data RAM between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. It latches one request at a time, drives a req/ack handshake to the RAM, and returns a one-cycle ready pulse with captured read data. It also produces the stall terms that hold the PC, IF/ID and the whole pipeline while an access is outstanding. A timeout counter aborts accesses the RAM never acknowledges.

## Interface
- ADDR_W, 32, address width (IF, MEM and RAM sides)
- DATA_W, 32, data width
- TIMEOUT, 16, busy cycles without ack before abort (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  IF stage wants the instruction at if_addr
- if_addr  in  ADDR_W  fetch address (PC)
- if_ready  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched instruction, registered, held until next fetch completes
- mem_rd  in  1  MEM stage load
- mem_wr  in  1  MEM stage store
- mem_addr  in  ADDR_W  load/store address (ALU result)
- mem_wdata  in  DATA_W  store data
- mem_ready  out  1  one-cycle pulse: data access complete
- mem_rdata  out  DATA_W  load data, registered, held until next load completes
- ram_req  out  1  RAM request, registered
- ram_we  out  1  1 = write, 0 = read, registered
- ram_addr  out  ADDR_W  RAM address, registered
- ram_wdata  out  DATA_W  RAM write data, registered
- ram_ack  in  1  RAM completion, sampled while ram_req = 1
- ram_rdata  in  DATA_W  RAM read data, valid in the ram_ack cycle
- pipe_stall  out  1  freeze ID/EX/MEM/WB registers
- fetch_stall  out  1  hold PC and IF/ID
- bus_err  out  1  sticky timeout flag

## Operation
- States: IDLE, IBUSY, DBUSY, RESP.
- IDLE:
  - If mem_rd|mem_wr, go to DBUSY and latch ram_addr←mem_addr, ram_wdata←mem_wdata, ram_we←mem_wr, ram_req←1.
  - Else if if_req, go to IBUSY and latch ram_addr←if_addr, ram_we←0, ram_req←1.
  - Data has fixed priority: it belongs to the older instruction.
- mem_rd and mem_wr both high: treated as a write.
- IBUSY/DBUSY: ram_req and the latched fields are held stable. Requester inputs are ignored. The wait counter increments each busy cycle.
- ram_ack = 1 in a busy cycle, at that edge:
  - ram_req←0.
  - Reads capture ram_rdata into if_rdata or mem_rdata.
  - Writes leave mem_rdata unchanged.
  - Set the matching ready register; go to RESP.
- Timeout: the wait counter reaches TIMEOUT with no ack:
  - ram_req←0, bus_err←1.
  - The rdata register for the access is loaded with 0.
  - Ready pulses as normal; go to RESP.
  - bus_err clears only on rst.
- RESP: exactly one cycle with the ready pulse high. New requests are not launched in RESP, because requester inputs are still those of the completed access. Then go to IDLE and clear the wait counter.
- Stall terms (combinational from registered state and inputs):
  - pipe_stall = (mem_rd|mem_wr) & ~mem_ready
  - fetch_stall = pipe_stall | (if_req & ~if_ready)
  - Top level drives pcWrite and IF_ID_RegWrite low while fetch_stall is high.
- rst (any time, including mid-access): state←IDLE, ram_req←0 immediately, no ready pulse for the aborted access, all outputs and registers 0, bus_err←0.

## Timing
- Request seen in IDLE in cycle t: ram_req is high from t+1.
- Ack in cycle t+k (k≥1): ready is high in t+k+1 and the state is IDLE in t+k+2.
- Minimum access time is 3 cycles from request to the next possible launch.
- Timeout access: ram_req high for TIMEOUT cycles, ready pulse in the following cycle.
- Back-to-back data then fetch, both pending from cycle t:
  - data ready at t+k+1
  - fetch launch decision in IDLE at t+k+2
- An ack while ram_req = 0 is ignored.
- ram_* fields never change while ram_req = 1.

## Test plan
- Reset then a single fetch: if_req=1, if_addr=0x40, RAM acks 2 cycles after ram_req with 0x8C220004. Required: if_ready pulses once, 3 cycles after ram_req rose; if_rdata=0x8C220004; fetch_stall high until that cycle.
- Simultaneous load and fetch: mem_rd=1 (addr 0x100), if_req=1 (addr 0x44). Required: the first ram_req has addr 0x100 and we=0; mem_ready precedes any ram_req for 0x44; pipe_stall is high throughout the load.
- Store: mem_wr=1, addr 0x200, wdata 0xDEADBEEF, ack immediate. Required: ram_we=1 with that data; mem_ready pulses once; mem_rdata unchanged from its prior value.
- Timeout: mem_rd=1 with ram_ack never high and TIMEOUT=16. Required: ram_req high exactly 16 cycles; then mem_ready=1, mem_rdata=0, bus_err=1 and it stays 1 until rst.
- Reset mid-access: assert rst during DBUSY. Required: ram_req=0 in the same cycle; no mem_ready; bus_err=0. After release, a new fetch completes normally.
- Held request: keep mem_rd high through RESP. Required: only one RAM access per completed handshake, with no relaunch during RESP.
